openneuro_tx_mii_framer: RTL

//  TX stage downstream of the OpenNeuro network controller TX FIFO. Pops 32-bit payload words
//  and serializes them onto a 4-bit MII-style PHY interface. Emits preamble/SFD, the payload

---
 rtl/openneuro_tx_mii_framer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/openneuro_tx_mii_framer.sv
// TX framer: pops 32-bit payload words and emits preamble/SFD, payload nibbles, optional FCS (OPENNEURO_TX_FCS_EN) and IFG on a 4-bit MII.
// Latency: first preamble nibble one cycle after the IDLE start decision; payload follows SFD with no bubble.
// Backpressure: s_ready pulses only on the SFD-high or word-final nibble; a missing word aborts the frame (underrun).
module openneuro_tx_mii_framer #(
    parameter int PREAMBLE_BYTES = 7,
    parameter int IFG_BYTES      = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_enable,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    input  logic        s_last,
    input  logic [1:0]  s_bytes,
    output logic        s_ready,
    output logic [3:0]  mii_txd,
    output logic        mii_tx_en,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun,
    output logic [15:0] tx_frames
);

`ifdef OPENNEURO_TX_FCS_EN
    typedef enum logic [2:0] {IDLE, PRE, DATA, FCS, IFG} state_t;
`else
    typedef enum logic [1:0] {IDLE, PRE, DATA, IFG} state_t;
`endif

    localparam logic [8:0] PRE_LAST = 9'(2 * PREAMBLE_BYTES + 1);
    localparam logic [8:0] IFG_LAST = 9'(2 * IFG_BYTES - 1);

    state_t      state, state_d;
    logic [8:0]  cnt, cnt_d;
    logic [31:0] hold;
    logic        hold_last;
    logic [2:0]  last_nib, last_nib_d;
    logic        underrun_q;
    logic [15:0] tx_frames_q;
    logic        load, done, abort;
    logic [3:0]  data_nib;

    assign data_nib = hold[{cnt[2:0], 2'b00} +: 4];

`ifdef OPENNEURO_TX_FCS_EN
    logic [31:0] crc;
    logic [3:0]  fcs_nib;

    function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 4; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    assign fcs_nib = ~crc[{cnt[2:0], 2'b00} +: 4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                crc <= '1;
        else if (state == PRE)  crc <= '1;
        else if (state == DATA) crc <= crc_nib(crc, data_nib);
    end
`endif

    // Last-word nibble index: 2*bytes-1, with s_bytes==0 meaning a full word.
    always_comb begin
        last_nib_d = 3'd7;
        if (s_last) begin
            case (s_bytes)
                2'd1:    last_nib_d = 3'd1;
                2'd2:    last_nib_d = 3'd3;
                2'd3:    last_nib_d = 3'd5;
                default: last_nib_d = 3'd7;
            endcase
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt + 9'd1;
        load      = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        s_ready   = 1'b0;
        mii_txd   = 4'h0;
        mii_tx_en = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (tx_enable && s_valid) state_d = PRE;
            end
            PRE: begin
                mii_tx_en = 1'b1;
                mii_txd   = (cnt == PRE_LAST) ? 4'hD : 4'h5;
                if (cnt == PRE_LAST) begin
                    s_ready = 1'b1;
                    cnt_d   = '0;
                    if (s_valid) begin
                        load    = 1'b1;
                        state_d = DATA;
                    end else begin
                        abort   = 1'b1;
                        state_d = IFG;
                    end
                end
            end
            DATA: begin
                mii_tx_en = 1'b1;
                mii_txd   = data_nib;
                if (cnt[2:0] == last_nib) begin
                    cnt_d = '0;
                    if (hold_last) begin
`ifdef OPENNEURO_TX_FCS_EN
                        state_d = FCS;
`else
                        done    = 1'b1;
                        state_d = IFG;
`endif
                    end else begin
                        s_ready = 1'b1;
                        if (s_valid) begin
                            load = 1'b1;
                        end else begin
                            abort   = 1'b1;
                            state_d = IFG;
                        end
                    end
                end
            end
`ifdef OPENNEURO_TX_FCS_EN
            FCS: begin
                mii_tx_en = 1'b1;
                mii_txd   = fcs_nib;
                if (cnt[2:0] == 3'd7) begin
                    done    = 1'b1;
                    cnt_d   = '0;
                    state_d = IFG;
                end
            end
`endif
            IFG: begin
                if (cnt == IFG_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            hold        <= '0;
            hold_last   <= 1'b0;
            last_nib    <= '0;
            underrun_q  <= 1'b0;
            tx_frames_q <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            underrun_q <= abort;
            if (load) begin
                hold      <= s_data;
                hold_last <= s_last;
                last_nib  <= last_nib_d;
            end
            if (done) tx_frames_q <= tx_frames_q + 16'd1;
        end
    end

    assign busy       = (state != IDLE);
    assign frame_done = done;
    assign underrun   = underrun_q;
    assign tx_frames  = tx_frames_q;

endmodule
